// File: rtl/os_drain_collector.sv
// Drains an output-stationary array one row per os_drain shift and writes each bottom row to the output buffer.
// A drain issues ROWS shifts and ROWS writes, bottom row first; a write waits in WRITE until wr_ready.
module os_drain_collector #(
   parameter int ROWS         = 4,
   parameter int COLS         = 4,
   parameter int PE_OUT_WIDTH = 32,
   parameter int ADDR_WIDTH   = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [ADDR_WIDTH-1:0]        base_addr,
   input  logic [COLS*PE_OUT_WIDTH-1:0] col_result_in,
   output logic                         os_drain,
   output logic                         act_gate,
   output logic                         wr_valid,
   input  logic                         wr_ready,
   output logic [ADDR_WIDTH-1:0]        wr_addr,
   output logic [COLS*PE_OUT_WIDTH-1:0] wr_data,
   output logic                         busy,
   output logic                         done
);
   localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [CW-1:0]         LAST_CNT = CW'(ROWS - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(ROWS - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

   state_t                       r_state;
   logic [CW-1:0]                r_cnt;
   logic [ADDR_WIDTH-1:0]        r_base;
   logic [ADDR_WIDTH-1:0]        r_wr_addr;
   logic [COLS*PE_OUT_WIDTH-1:0] r_data;
   logic                         r_os_drain;
   logic                         r_busy;
   logic                         r_wr_valid;
   logic                         r_done;
   logic [ADDR_WIDTH-1:0]        w_row_addr;

   // cnt counts rows already drained, so the row now at the bottom is ROWS-1-cnt
   assign w_row_addr = r_base + LAST_ROW - ADDR_WIDTH'(r_cnt);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_base     <= '0;
         r_wr_addr  <= '0;
         r_data     <= '0;
         r_os_drain <= 1'b0;
         r_busy     <= 1'b0;
         r_wr_valid <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_base     <= base_addr;
                  r_cnt      <= '0;
                  r_os_drain <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_data     <= col_result_in;
               r_wr_addr  <= w_row_addr;
               r_os_drain <= 1'b0;
               r_wr_valid <= 1'b1;
               r_state    <= S_WRITE;
            end
            S_WRITE: begin
               if (wr_ready) begin
                  r_wr_valid <= 1'b0;
                  if (r_cnt == LAST_CNT) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_cnt      <= r_cnt + 1'b1;
                     r_os_drain <= 1'b1;
                     r_state    <= S_LOAD;
                  end
               end
            end
            default: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign os_drain = r_os_drain;
   assign act_gate = r_busy;
   assign busy     = r_busy;
   assign wr_valid = r_wr_valid;
   assign wr_addr  = r_wr_addr;
   assign wr_data  = r_data;
   assign done     = r_done;

endmodule

// File: tb/tb_os_drain_collector.sv
// Bench for os_drain_collector: models the array columns and checks every drain against an expected write list.
module tb_os_drain_collector;
   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int PW   = 32;
   localparam int AW   = 8;
   localparam int DW   = COLS * PW;

   logic          clk;
   logic          reset;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [DW-1:0] col_in;
   logic          os_drain;
   logic          act_gate;
   logic          wr_valid;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          busy;
   logic          done;

   logic [PW-1:0] pre [ROWS][COLS];
   logic [PW-1:0] acc [ROWS][COLS];
   logic          load_req;

   int errors = 0;
   int checks = 0;

   os_drain_collector #(.ROWS(ROWS), .COLS(COLS), .PE_OUT_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .col_result_in(col_in), .os_drain(os_drain), .act_gate(act_gate),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Array columns: zeros enter at the top on each shift, the bottom row feeds the collector
   always @(posedge clk) begin
      if (load_req) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) acc[r][c] <= pre[r][c];
      end else if (os_drain) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) acc[r][c] <= (r == 0) ? '0 : acc[r-1][c];
      end
   end

   always_comb begin
      col_in = '0;
      for (int c = 0; c < COLS; c++) col_in[c*PW +: PW] = acc[ROWS-1][c];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [DW-1:0] row_vec(input int r);
      logic [DW-1:0] v;
      v = '0;
      for (int c = 0; c < COLS; c++) v[c*PW +: PW] = pre[r][c];
      return v;
   endfunction

   task automatic load_pattern();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) pre[r][c] = 32'(100 * r + c);
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
   endtask

   task automatic load_random();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) pre[r][c] = $urandom;
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_os_drain"}, os_drain, 0);
      chk({tag, "_act_gate"}, act_gate, 0);
      chk({tag, "_wr_valid"}, wr_valid, 0);
      chk({tag, "_wr_addr"},  wr_addr, 0);
      chk({tag, "_wr_data"},  wr_data, 0);
      chk({tag, "_busy"},     busy, 0);
      chk({tag, "_done"},     done, 0);
   endtask

   // One full drain; start_mask[n] re-pulses start (with a different base) during cycle n
   task automatic drain(input logic [AW-1:0] base, input int stall_idx, input int stall_len,
                        input logic [31:0] start_mask);
      logic [AW-1:0] q_addr [$];
      logic [DW-1:0] q_data [$];
      logic          exp_drain, exp_done, fin;
      logic [PW-1:0] orv;
      int            n, nwr, left, nst;
      for (int k = 0; k < ROWS; k++) begin
         q_addr.push_back(base + AW'(ROWS - 1 - k));
         q_data.push_back(row_vec(ROWS - 1 - k));
      end
      base_addr = base;
      wr_ready  = 1'b1;
      start     = 1'b1;
      tick();
      start = 1'b0;
      n = 1; nwr = 0; nst = 0; left = stall_len;
      exp_drain = 1'b1; exp_done = 1'b0; fin = 1'b0;
      while (!fin && n < 200) begin
         chk("done", done, exp_done);
         chk("os_drain", os_drain, exp_drain);
         chk("busy", busy, !exp_done);
         chk("act_gate", act_gate, !exp_done);
         if (exp_done) begin
            chk("done_cycle", n, 2 * ROWS + 1 + nst);
            chk("write_count", nwr, ROWS);
            fin = 1'b1;
         end else begin
            chk("wr_valid", wr_valid, !exp_drain);
            exp_drain = 1'b0;
            wr_ready  = 1'b1;
            if (wr_valid && q_addr.size() > 0) begin
               chk("wr_addr", wr_addr, q_addr[0]);
               chk("wr_data", wr_data, q_data[0]);
               if (nwr == stall_idx && left > 0) begin
                  wr_ready = 1'b0;
                  left--;
                  nst++;
               end else begin
                  void'(q_addr.pop_front());
                  void'(q_data.pop_front());
                  nwr++;
                  exp_drain = (q_addr.size() > 0);
                  exp_done  = (q_addr.size() == 0);
               end
            end
         end
         start     = start_mask[n];
         base_addr = start_mask[n] ? ~base : base;
         tick();
         n++;
      end
      start = 1'b0; base_addr = base; wr_ready = 1'b1;
      if (!fin) chk("drain_timeout", 0, 1);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_wr_valid", wr_valid, 0);
      chk("idle_os_drain", os_drain, 0);
      tick();
      chk("idle2_busy", busy, 0);
      chk("idle2_os_drain", os_drain, 0);
      orv = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) orv = orv | acc[r][c];
      chk("array_cleared", orv, 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; base_addr = '0; wr_ready = 1'b1; load_req = 1'b0;
      #1;
      check_reset_outputs("rst_async");
      tick();
      tick();
      check_reset_outputs("rst_hold");
      reset = 1'b0;
      tick();
      check_reset_outputs("post_rst");

      load_pattern();
      drain(8'h10, 99, 0, 32'h0);

      load_pattern();
      drain(8'h10, 1, 3, 32'h0);

      load_random();
      pre[1][2] = 32'hFFFF_FFFF;
      pre[3][0] = 32'h8000_0000;
      pre[0][3] = 32'h8000_0000;
      load_req = 1'b1; tick(); load_req = 1'b0;
      drain(AW'($urandom), 99, 0, 32'h0);

      load_random();
      drain(8'hFE, 99, 0, 32'h0);

      load_pattern();
      drain(8'h10, 99, 0, (32'h1 << 3) | (32'h1 << 9));

      load_pattern();
      base_addr = 8'h20;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      chk("pre_abort_busy", busy, 1);
      reset = 1'b1;
      #1;
      check_reset_outputs("abort");
      tick();
      check_reset_outputs("abort_hold");
      reset = 1'b0;
      tick();
      check_reset_outputs("abort_idle");
      load_pattern();
      drain(8'h40, 99, 0, 32'h0);

      for (int i = 0; i < 4; i++) begin
         load_random();
         drain(AW'($urandom), $urandom_range(0, ROWS - 1), $urandom_range(0, 4), 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
